mem_port_arbiter: RTL and testbench

//  Shares the single-port instruction/data RAM between two masters.
//  - m0: the CPU FSM, for instruction fetch and LDR/STR.
//  - m1: a secondary master, e.g. a loader or DMA engine.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_rr_sel.sv | 23 ++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: RAM command encodings
// (also used by the CPU FSM) and the arbiter state type.
package mem_arb_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  // True for the two encodings that actually touch the RAM.
  function automatic logic cmd_is_access(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_arb_rr_sel.sv
// Combinational 2-way round-robin pick. A non-zero lock_own_i mask
// restricts eligibility to the locked owner; on a tie the master that
// was not granted last wins.
module mem_arb_rr_sel
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic [1:0] lock_own_i,
  output logic       valid_o,
  output logic       winner_o
);

  logic [1:0] elig;

  // Mask by lock owner, then break ties against the last winner.
  always_comb begin
    elig     = (lock_own_i != 2'b00) ? (req_i & lock_own_i) : req_i;
    valid_o  = |elig;
    winner_o = (elig == 2'b11) ? ~last_i : elig[1];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port instruction/data RAM between the CPU FSM (m0)
// and a secondary master (m1). Round-robin, one transaction in flight.
// Sequence: IDLE -> ACC -> (RD) -> DONE -> IDLE; all outputs registered.
// Handshake: a master raises mX_req with stable cmd/addr/wdata and holds
// it until it samples mX_done=1, dropping req at that same edge; mX_gnt
// is high for ACC/RD/DONE of its own transaction only.
// Optional feature: define MEM_ARB_LOCK_EN to add m0_lock/m1_lock, which
// let the current winner keep the port across consecutive transactions.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 9,
  parameter int DW      = 16,
  parameter bit RR_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [1:0]    m0_cmd,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [1:0]    m1_cmd,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output arb_state_t    dbg_state
);

  arb_state_t    state_q;
  logic          win_q, last_q;
  logic          m0_gnt_q, m1_gnt_q, m0_done_q, m1_done_q;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;
  logic [1:0]    mem_cmd_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic          sel_valid, sel_win;
  logic [1:0]    lock_own;
  logic [1:0]    sel_cmd;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef MEM_ARB_LOCK_EN
  logic lock_q, lock_owner_q;

  // Lock stays in force only while the owner still holds its lock input.
  always_comb begin
    lock_own = 2'b00;
    if (lock_q && (lock_owner_q ? m1_lock : m0_lock))
      lock_own = lock_owner_q ? 2'b10 : 2'b01;
  end
`else
  assign lock_own = 2'b00;
`endif

  mem_arb_rr_sel u_sel (
    .req_i      ({m1_req, m0_req}),
    .last_i     (last_q),
    .lock_own_i (lock_own),
    .valid_o    (sel_valid),
    .winner_o   (sel_win)
  );

  // Route the prospective winner's request fields.
  always_comb begin
    sel_cmd   = sel_win ? m1_cmd   : m0_cmd;
    sel_addr  = sel_win ? m1_addr  : m0_addr;
    sel_wdata = sel_win ? m1_wdata : m0_wdata;
  end

  // Arbiter FSM with registered grant/done/rdata and RAM drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      last_q      <= ~RR_INIT;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      mem_cmd_q   <= MNONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef MEM_ARB_LOCK_EN
          if (lock_own == 2'b00) lock_q <= 1'b0;
`endif
          if (sel_valid) begin
            state_q     <= ACC;
            win_q       <= sel_win;
            // Unknown commands are sequenced like a write but never reach RAM.
            mem_cmd_q   <= cmd_is_access(sel_cmd) ? sel_cmd : MNONE;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            if (sel_win) m1_gnt_q <= 1'b1;
            else         m0_gnt_q <= 1'b1;
          end
        end
        ACC: begin
          if (mem_cmd_q == MREAD) begin
            state_q <= RD;
          end else begin
            state_q   <= DONE;
            mem_cmd_q <= MNONE;
            if (win_q) m1_done_q <= 1'b1;
            else       m0_done_q <= 1'b1;
          end
        end
        RD: begin
          state_q   <= DONE;
          mem_cmd_q <= MNONE;
          if (win_q) begin
            m1_rdata_q <= mem_rdata;
            m1_done_q  <= 1'b1;
          end else begin
            m0_rdata_q <= mem_rdata;
            m0_done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          last_q    <= win_q;
          m0_gnt_q  <= 1'b0;
          m1_gnt_q  <= 1'b0;
          m0_done_q <= 1'b0;
          m1_done_q <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
          lock_q       <= win_q ? m1_lock : m0_lock;
          lock_owner_q <= win_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_done   = m0_done_q;
  assign m1_done   = m1_done_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, two master driver tasks, and a
// scoreboard of {master, rdata} completions checked by a done monitor.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int W  = 1 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          m0_req, m1_req;
  logic [1:0]    m0_cmd, m1_cmd;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_done, m1_done;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  arb_state_t    dbg_state;
`ifdef MEM_ARB_LOCK_EN
  logic          m0_lock, m1_lock;
`endif

  mem_port_arbiter #(.AW(AW), .DW(DW), .RR_INIT(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_cmd    (m0_cmd),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_done   (m0_done),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_cmd    (m1_cmd),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_done   (m1_done),
    .m1_rdata  (m1_rdata),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock   (m0_lock),
    .m1_lock   (m1_lock),
`endif
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- RAM model (read data one cycle after MREAD) ----------------
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_cmd == MWRITE) ram[mem_addr] <= mem_wdata;
    if (mem_cmd == MREAD) mem_rdata <= ram[mem_addr];
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the next expected completion.
  always @(negedge clk) begin
    if (!reset && (m0_done || m1_done)) begin
      if (m0_done && m1_done) begin
        chk("both_done", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'd0, m1_done}, 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_master", {31'd0, m1_done}, {31'd0, e[W-1]});
        chk("sb_rdata", m1_done ? m1_rdata : m0_rdata, {16'd0, e[DW-1:0]});
      end
    end
  end

  // Flags any RAM command while a no-access request is in flight.
  logic watch_none = 1'b0;
  logic none_bad = 1'b0;
  always @(negedge clk) if (watch_none && mem_cmd != MNONE) none_bad <= 1'b1;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  // Issues one request, waits (bounded) for done, drops req at that edge.
  // exp_lat > 0 checks cycles from req-raise to done.
  task automatic drive(input bit m, input logic [1:0] cmd, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input int exp_lat);
    int  start;
    bit  seen;
    if (m) begin m1_req = 1'b1; m1_cmd = cmd; m1_addr = addr; m1_wdata = wd; end
    else   begin m0_req = 1'b1; m0_cmd = cmd; m0_addr = addr; m0_wdata = wd; end
    start = cyc;
    seen  = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = m ? m1_done : m0_done;
    end
    if (!seen) chk($sformatf("m%0d_timeout", m), 32'd0, 32'd1);
    else if (exp_lat > 0) chk($sformatf("m%0d_latency", m), cyc - start, exp_lat);
    @(posedge clk); #1;
    if (m) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    m0_req = 0; m0_cmd = MNONE; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_cmd = MNONE; m1_addr = '0; m1_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif

    // 1. Reset held; RAM preloaded meanwhile.
    preload(9'h010, 16'hABCD);
    preload(9'h040, 16'hB000);
    preload(9'h041, 16'hB001);
    preload(9'h042, 16'hB002);
    @(negedge clk);
    chk("rst_gnt",   {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_done",  {30'd0, m1_done, m0_done}, 32'd0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 32'd0);
    chk("rst_mem",   {mem_cmd, mem_addr, mem_wdata}, 32'd0);
    chk("rst_state", dbg_state, IDLE);
    tick();
    reset = 1'b0;

    // 2. m0 read 0x010 with cycle-accurate checks.
    exp_q.push_back({1'b0, 16'hABCD});
    m0_req = 1'b1; m0_cmd = MREAD; m0_addr = 9'h010;
    @(negedge clk); chk("rd_c0_cmd", mem_cmd, MNONE);
    tick(); @(negedge clk);
    chk("rd_c1_cmd", mem_cmd, MREAD);
    chk("rd_c1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    tick(); @(negedge clk);
    chk("rd_c2_cmd", mem_cmd, MREAD);
    chk("rd_c2_addr", mem_addr, 9'h010);
    chk("rd_c2_done", m0_done, 1'b0);
    tick(); @(negedge clk);
    chk("rd_c3_done", m0_done, 1'b1);
    chk("rd_c3_rdata", m0_rdata, 16'hABCD);
    chk("rd_c3_cmd", mem_cmd, MNONE);
    chk("rd_m1_quiet", {m1_gnt, m1_done, m1_rdata}, 32'd0);
    tick();
    m0_req = 1'b0;
    tick();

    // 3. Fresh reset, simultaneous m0 write / m1 read of the same address.
    do_reset(2);
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b1, 16'h1234});
    fork
      drive(1'b0, MWRITE, 9'h020, 16'h1234, 2);
      drive(1'b1, MREAD,  9'h020, 16'h0000, 6);
    join
    tick();

    // 4. Both masters continuously requesting: strict alternation from m0.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 16'h0000});
      exp_q.push_back({1'b1, 16'hB000 + 16'(i)});
    end
    fork
      for (int i = 0; i < 3; i++) drive(1'b0, MWRITE, 9'h030 + 9'(i), 16'hA000 + 16'(i), 0);
      for (int j = 0; j < 3; j++) drive(1'b1, MREAD, 9'h040 + 9'(j), 16'h0000, 0);
    join
    tick();

    // 7. Non-access command: no RAM traffic, write-like latency, rdata kept.
    exp_q.push_back({1'b1, 16'hB002});
    watch_none = 1'b1;
    drive(1'b1, 2'b11, 9'h1FF, 16'hFFFF, 2);
    watch_none = 1'b0;
    chk("none_cmd", {31'd0, none_bad}, 32'd0);
    tick();

    // 8. Readback of a write committed during the alternation run.
    exp_q.push_back({1'b0, 16'hA002});
    drive(1'b0, MREAD, 9'h032, 16'h0000, 3);
    tick();

    // 5. Reset while in RD, then re-issue the read.
    m0_req = 1'b1; m0_cmd = MREAD; m0_addr = 9'h041;
    tick(); tick();
    @(negedge clk);
    chk("mid_state_rd", dbg_state, RD);
    reset = 1'b1;
    m0_req = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_state_idle", dbg_state, IDLE);
    chk("mid_cmd", mem_cmd, MNONE);
    chk("mid_done_gnt", {28'd0, m0_done, m1_done, m0_gnt, m1_gnt}, 32'd0);
    tick(); tick();
    exp_q.push_back({1'b0, 16'hB001});
    drive(1'b0, MREAD, 9'h041, 16'h0000, 3);
    tick();

    // 6. m1 two ops vs m0 one op; m0 was last served so m1 leads.
`ifdef MEM_ARB_LOCK_EN
    exp_q.push_back({1'b1, 16'hB000});
    exp_q.push_back({1'b1, 16'hB002});
    exp_q.push_back({1'b0, 16'hB001});
    m1_lock = 1'b1;
`else
    exp_q.push_back({1'b1, 16'hB000});
    exp_q.push_back({1'b0, 16'hB001});
    exp_q.push_back({1'b1, 16'hB002});
`endif
    fork
      begin
        drive(1'b1, MREAD, 9'h040, 16'h0000, 0);
        drive(1'b1, MREAD, 9'h042, 16'h0000, 0);
`ifdef MEM_ARB_LOCK_EN
        m1_lock = 1'b0;
`endif
      end
      drive(1'b0, MWRITE, 9'h050, 16'h5555, 0);
    join
    repeat (3) tick();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
